mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 33, meaning cycles in RUN between the mul_load pulse and a valid mul_result; legal range 1..63.
REQ-002 SHALL have port Clock  in  1  rising-edge clock for all state.
REQ-003 SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  in  1  MULT/MULTU issue request.
REQ-005 SHALL have port is_signed  in  1  1 = MULT, 0 = MULTU; sampled with start.
REQ-006 SHALL have ports op_a, op_b  in  32 each  operands; sampled with start.
REQ-007 SHALL have port mf_req  in  1  MFHI/MFLO read request.
REQ-008 SHALL have port mf_sel  in  1  0 = LO, 1 = HI.
REQ-009 SHALL have port mul_load  out  1  one-cycle start pulse to the iterative multiplier.
REQ-010 SHALL have ports mul_a, mul_b  out  32 each  multiplier operands, held stable from LOAD through RUN.
REQ-011 SHALL have port mul_result  in  64  unsigned product from the multiplier.
REQ-012 SHALL have ports busy, done, stall  out  1 each  operation in flight; capture pulse; pipeline hold.
REQ-013 SHALL have ports hi, lo, mf_data  out  32 each  HI register, LO register, selected read data.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, CAPTURE.
REQ-015 IDLE: start=1 latches operands and is_signed, then goes to LOAD; start=0 stays in IDLE.
REQ-016 LOAD: mul_load=1 for exactly one cycle; clears the 6-bit run counter; goes to RUN.
REQ-017 RUN: increments the counter each cycle; goes to CAPTURE after exactly LATENCY cycles.
REQ-018 CAPTURE: writes hi=result[63:32] and lo=result[31:0] at the end of the cycle; done=1 for that one cycle; goes to IDLE.
REQ-019 Timing: start sampled at cycle 0, so mul_load is at cycle 1, done at cycle LATENCY+2, and new hi/lo are visible at cycle LATENCY+3.
REQ-020 busy SHALL be 1 in LOAD, RUN and CAPTURE, and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored, with stall=1 that cycle; the pipeline re-presents it.
REQ-022 stall SHALL equal busy AND (mf_req OR start).
REQ-023 mf_data SHALL be combinational: mf_sel ? hi : lo.
REQ-024 mf_req with start in the same IDLE cycle SHALL return old hi/lo with stall=0.
REQ-025 mf_req in CAPTURE SHALL give stall=1; the request re-presented next cycle SHALL return the new value.
REQ-026 mul_result SHALL be sampled only in CAPTURE; changes on it at other times SHALL have no effect.

Reset
REQ-027 Reset_n=0 SHALL asynchronously force IDLE, counter=0, hi=lo=0, mul_a=mul_b=0, and mul_load=busy=done=0.
REQ-028 Reset mid-operation SHALL abandon it without writing hi/lo; start SHALL be accepted in the first cycle after Reset_n rises.

Configuration
REQ-029 Macro SIGNED_MUL_EN defined: when is_signed=1, mul_a/mul_b SHALL be operand magnitudes (0x80000000 maps to 0x80000000), and the 64-bit result SHALL be two's-complement negated in CAPTURE when the operand signs differ.
REQ-030 Macro SIGNED_MUL_EN undefined: is_signed SHALL be ignored; operands pass through unchanged and the result is unsigned.

Verification
REQ-031 Reset_n low, then high -> hi=lo=0, busy=done=stall=0, mul_load=0.
REQ-032 start, is_signed=0, op_a=3, op_b=5, model returns 15 -> mul_load at cycle 1, done at cycle 35 (LATENCY=33), hi=0x00000000, lo=0x0000000F.
REQ-033 is_signed=0, op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 is_signed=1, op_a=0xFFFFFFFD, op_b=5 -> macro on: mul_a=3, hi=0xFFFFFFFF, lo=0xFFFFFFF1; macro off: hi=0x00000004, lo=0xFFFFFFF1.
REQ-035 mf_req=1, mf_sel=1 held from cycle 2 -> stall=1 through cycle 35, stall=0 at cycle 36 with mf_data = new hi; second start at cycle 10 ignored, stall=1.
REQ-036 Reset_n pulsed low at cycle 20 of RUN -> IDLE, hi/lo=0, no done; a new start afterwards completes normally.

Source files
------------

// File: rtl/mult_ctrl.sv
// mult_ctrl: control for an iterative MULT/MULTU unit with HI/LO result registers.
//
// Sequencing is IDLE -> LOAD -> RUN -> CAPTURE -> IDLE. The multiplier gets a
// one-cycle mul_load pulse. Its product is taken only in CAPTURE, after LATENCY
// cycles in RUN.
//
// Parameters:
//   LATENCY    - cycles spent in RUN before the product is valid (1..63)
//
// Build option:
//   SIGNED_MUL_EN - when defined, MULT (is_signed=1) sends operand magnitudes to
//                   the multiplier and negates the 64-bit product when the
//                   operand signs differ. When undefined, is_signed is ignored.
//
// Ports:
//   Clock, Reset_n        - rising-edge clock, async active-low reset
//   start, is_signed      - issue request and signedness, sampled in IDLE
//   op_a, op_b            - 32-bit operands, sampled with start
//   mf_req, mf_sel        - MFHI/MFLO read request, 0 = LO / 1 = HI
//   mul_load              - one-cycle start pulse to the multiplier
//   mul_a, mul_b          - operands to the multiplier, held from LOAD through RUN
//   mul_result            - 64-bit unsigned product from the multiplier
//   busy, done, stall     - op in flight, capture pulse, pipeline hold
//   hi, lo, mf_data       - result registers and selected read data
module mult_ctrl #(
  parameter int unsigned LATENCY = 33
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic        mul_load,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StCapture} state_e;

  localparam logic [5:0] CntLast = 6'(LATENCY - 1);

  state_e      r_state, w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_mul_a, r_mul_b;
  logic [31:0] r_hi, r_lo;
  logic [31:0] w_opnd_a, w_opnd_b;
  logic [63:0] w_result;

`ifdef SIGNED_MUL_EN
  logic r_neg;

  // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude
  // when read as unsigned.
  always_comb begin
    w_opnd_a = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    w_opnd_b = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
    w_result = r_neg ? (~mul_result + 64'd1) : mul_result;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_neg <= 1'b0;
    end else if (r_state == StIdle && start) begin
      r_neg <= is_signed & (op_a[31] ^ op_b[31]);
    end
  end
`else
  logic w_unused_is_signed;
  assign w_unused_is_signed = is_signed;

  always_comb begin
    w_opnd_a = op_a;
    w_opnd_b = op_b;
    w_result = mul_result;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (start) w_state_nxt = StLoad;
      StLoad:    w_state_nxt = StRun;
      StRun:     if (r_cnt == CntLast) w_state_nxt = StCapture;
      StCapture: w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mul_a <= w_opnd_a;
            r_mul_b <= w_opnd_b;
          end
        end
        StLoad:    r_cnt <= '0;
        StRun:     r_cnt <= r_cnt + 6'd1;
        StCapture: begin
          r_hi <= w_result[63:32];
          r_lo <= w_result[31:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mul_load = (r_state == StLoad);
    busy     = (r_state != StIdle);
    done     = (r_state == StCapture);
    // Held requests are re-presented by the pipeline once busy drops.
    stall    = busy & (mf_req | start);
    mul_a    = r_mul_a;
    mul_b    = r_mul_b;
    hi       = r_hi;
    lo       = r_lo;
    mf_data  = mf_sel ? r_hi : r_lo;
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Testbench for mult_ctrl. The stimulus pushes the expected HI/LO value and the
// expected done cycle into a scoreboard. A monitor pops an entry on each done and
// checks HI/LO one cycle later.
module tb_mult_ctrl;

  localparam int unsigned LAT = 33;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mf_req = 1'b0;
  logic        mf_sel = 1'b0;
  logic        mul_load;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        busy, done, stall;
  logic [31:0] hi, lo, mf_data;

  mult_ctrl #(.LATENCY(LAT)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .start      (start),
    .is_signed  (is_signed),
    .op_a       (op_a),
    .op_b       (op_b),
    .mf_req     (mf_req),
    .mf_sel     (mf_sel),
    .mul_load   (mul_load),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo),
    .mf_data    (mf_data)
  );

  always #5 Clock = ~Clock;

  // Multiplier model: the product is valid only during the capture cycle and is
  // junk at all other times.
  assign mul_result = done ? ({32'b0, mul_a} * {32'b0, mul_b}) : 64'hA5A5_5A5A_DEAD_BEEF;

  int cyc = 0;
  always @(posedge Clock) cyc = cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: done must come at the predicted cycle, and HI/LO must hold the
  // predicted values in the next cycle.
  always @(negedge Clock) begin
    if (pend) begin
      chk("hi_result", {32'b0, hi}, {32'b0, cur.hi});
      chk("lo_result", {32'b0, lo}, {32'b0, cur.lo});
      pend = 1'b0;
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected no done", cyc);
      end else begin
        cur = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(cur.cyc));
        pend = 1'b1;
      end
    end
  end

  task automatic next_cyc();
    @(posedge Clock);
    #1;
  endtask

  // Call this at posedge+1. It presents start in the current cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    exp_t e;
    start     = 1'b1;
    is_signed = s;
    op_a      = a;
    op_b      = b;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.cyc = cyc + LAT + 2;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (busy === 1'b0) break;
    end
    chk("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset: asynchronous assertion, then release.
    #1 Reset_n = 1'b0;
    #3;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_mul_load", {63'b0, mul_load}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) next_cyc();
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("post_rst_hilo", {hi, lo}, 64'd0);
    chk("post_rst_flags", {60'b0, busy, done, stall, mul_load}, 64'd0);

    // 3 * 5 unsigned: check the pulse timing and that the operands are held.
    next_cyc();
    issue(32'd3, 32'd5, 1'b0, 32'h0, 32'hF, 1'b1);
    @(negedge Clock);
    chk("c0_busy", {63'b0, busy}, 64'd0);
    next_cyc();
    start = 1'b0;
    @(negedge Clock);
    chk("c1_mul_load", {63'b0, mul_load}, 64'd1);
    chk("c1_busy", {63'b0, busy}, 64'd1);
    next_cyc();
    @(negedge Clock);
    chk("c2_mul_load", {63'b0, mul_load}, 64'd0);
    chk("c2_operands", {mul_a, mul_b}, {32'd3, 32'd5});
    wait_idle();

    // Largest unsigned operands.
    next_cyc();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    next_cyc();
    start = 1'b0;
    wait_idle();

    // Signed -3 * 5.
    next_cyc();
`ifdef SIGNED_MUL_EN
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
`else
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1, 1'b1);
`endif
    next_cyc();
    start = 1'b0;
    @(negedge Clock);
`ifdef SIGNED_MUL_EN
    chk("signed_mul_a", {32'b0, mul_a}, 64'd3);
`else
    chk("signed_mul_a", {32'b0, mul_a}, 64'h0000_0000_FFFF_FFFD);
`endif
    wait_idle();

    // A read issued with start returns the old LO without a stall. A HI read held
    // from cycle 2 stalls through capture, and a second start in RUN is ignored.
    next_cyc();
    issue(32'h0001_0000, 32'h0003_0000, 1'b0, 32'h0000_0003, 32'h0, 1'b1);
    mf_req = 1'b1;
    mf_sel = 1'b0;
    @(negedge Clock);
    chk("rd_with_start_stall", {63'b0, stall}, 64'd0);
    chk("rd_with_start_data", {32'b0, mf_data}, 64'h0000_0000_FFFF_FFF1);
    for (int k = 1; k <= 36; k++) begin
      next_cyc();
      mf_req = (k >= 2);
      mf_sel = 1'b1;
      start  = (k == 10);
      if (k == 10) begin
        op_a = 32'd11;
        op_b = 32'd13;
      end
      @(negedge Clock);
      chk($sformatf("stall_c%0d", k), {63'b0, stall}, {63'b0, (k >= 2 && k <= 35)});
      if (k == 36) chk("mfhi_new", {32'b0, mf_data}, 64'd3);
    end
    next_cyc();
    mf_req = 1'b0;
    start  = 1'b0;
    @(negedge Clock);
    chk("ignored_start_idle", {63'b0, busy}, 64'd0);

    // Reset in the middle of RUN abandons the operation.
    next_cyc();
    issue(32'd2, 32'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      next_cyc();
      start = 1'b0;
    end
    Reset_n = 1'b0;
    #2;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_flags", {61'b0, busy, done, mul_load}, 64'd0);
    chk("midrst_mul_a", {32'b0, mul_a}, 64'd0);
    next_cyc();
    Reset_n = 1'b1;
    issue(32'd6, 32'd7, 1'b0, 32'h0, 32'h2A, 1'b1);
    next_cyc();
    start = 1'b0;
    @(negedge Clock);
    chk("post_rst_accept", {63'b0, mul_load}, 64'd1);
    wait_idle();

    repeat (3) @(negedge Clock);
    chk("sb_drained", 64'(sb.size() + int'(pend)), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
